// File: rtl/bcd_mw_add_seq_if.sv
// Request/result handshake bundle for the multi-word BCD addition sequencer.
// master = requester/consumer side, slave = sequencer side.
interface bcd_mw_add_seq_if #(
  parameter int WORDS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [16*WORDS-1:0]   in_a;
  logic [16*WORDS-1:0]   in_b;
  logic                  in_cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [16*WORDS-1:0]   out_sum;
  logic                  out_cout;
  logic                  out_err;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_err
  );
endinterface

// File: rtl/bcd_mw_add_seq.sv
// Multi-word BCD adder sequencer: walks WORDS 16-bit words LS-first through one
// shared external combinational bcd_adder16, rippling the decimal carry in a register.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1, adder inputs quiescent
// RUN   | one word per cycle through the shared adder, idx selects the word
// DONE  | result presented with out_valid=1 until out_ready
module bcd_mw_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd_mw_add_seq_if.slave     req,
  output logic [15:0]         add_a,
  output logic [15:0]         add_b,
  output logic                add_cin,
  input  logic [15:0]         add_sum,
  input  logic                add_cout
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [16*WORDS-1:0] a_q, a_d;
  logic [16*WORDS-1:0] b_q, b_d;
  logic [16*WORDS-1:0] sum_q, sum_d;
  logic                carry_q, carry_d;
  logic                cout_q, cout_d;
  logic                err_q, err_d;
  logic                nib_err;
  logic                in_ready_c;
  logic                out_valid_c;

  always_comb begin
    nib_err = 1'b0;
    for (int i = 0; i < 4*WORDS; i++) begin
      if ((req.in_a[4*i +: 4] > 4'd9) || (req.in_b[4*i +: 4] > 4'd9)) nib_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    err_d       = err_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    add_a       = '0;
    add_b       = '0;
    add_cin     = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (req.in_valid) begin
          a_d     = req.in_a;
          b_d     = req.in_b;
          carry_d = req.in_cin;
          idx_d   = '0;
          err_d   = nib_err;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        add_a   = a_q[16*idx_q +: 16];
        add_b   = b_q[16*idx_q +: 16];
        add_cin = carry_q;
        sum_d[16*idx_q +: 16] = add_sum;
        carry_d = add_cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(WORDS-1)) begin
          cout_d  = add_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid_c = 1'b1;
        if (req.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req.in_ready  = in_ready_c;
  assign req.out_valid = out_valid_c;
  assign req.out_sum   = sum_q;
  assign req.out_cout  = cout_q;
  assign req.out_err   = err_q;

endmodule
